// File: rtl/timer_pkg.sv
// Shared definitions for the parametrised APB timer: register addresses,
// control/status bit positions and the clock-select encoding.
// Pure declarations; no logic, no latency, no flow control.
package timer_pkg;

    // Register map, byte addresses on the APB bus.
    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;
    localparam logic [7:0] ADDR_TCMP = 8'h04;
    localparam logic [7:0] ADDR_TIER = 8'h05;

    // TCR bit positions; [2:0] holds the clock select.
    localparam int TCR_LOAD = 7;
    localparam int TCR_ARE  = 6;
    localparam int TCR_DOWN = 5;
    localparam int TCR_EN   = 4;
    localparam int TCR_OSM  = 3;

    // TSR flag positions; TIER uses the same positions for its enables.
    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;
    localparam int TSR_CMF = 2;

    // Clock select: divisor is 2^(cks+1). The first four match the legacy timer.
    typedef enum logic [2:0] {
        CKS_CLK2   = 3'd0,
        CKS_CLK4   = 3'd1,
        CKS_CLK8   = 3'd2,
        CKS_CLK16  = 3'd3,
        CKS_CLK32  = 3'd4,
        CKS_CLK64  = 3'd5,
        CKS_CLK128 = 3'd6,
        CKS_CLK256 = 3'd7
    } cks_e;

    // Terminal prescaler count (divisor - 1) for a clock select.
    function automatic logic [7:0] cks_limit(input cks_e cks);
        return 8'((9'd2 << cks) - 9'd1);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a one-cycle tick every 2^(cks+1) pclk while run is high.
// Latency: tick is combinational from the internal count; count clears while run is low.
// Ports: pclk, presetn (sync, active-low), run, cks -> tick. No backpressure.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic pclk,
    input  logic presetn,
    input  logic run,
    input  cks_e cks,
    output logic tick
);

    logic [7:0] cnt;
    logic [7:0] limit;

    assign limit = cks_limit(cks);
    // A clock-select change does not reset the count; if the count is already
    // above the new limit it runs on, wraps through 0 and ticks at the new limit.
    assign tick  = run && (cnt == limit);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cnt <= 8'd0;
        end else if (!run || tick) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/timer_param.sv
// WIDTH-bit up/down timer behind a zero-wait-state APB slave, with reload,
// one-shot, compare match and a maskable registered interrupt.
// Ports: APB (psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr), tmr_irq.
module timer_param
    import timer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [WIDTH-1:0]  pwdata,
    output logic [WIDTH-1:0]  prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tmr_irq
);

    logic [WIDTH-1:0] tdr;
    logic [WIDTH-1:0] tcnt;
    logic [WIDTH-1:0] tcmp;
    logic [7:0]       tcr;
    logic [2:0]       tsr;
    logic [2:0]       tier;

    logic sel_tdr, sel_tcr, sel_tsr, sel_tcnt, sel_tcmp, sel_tier, mapped;
    logic access, wr;
    logic tick;
    logic [WIDTH-1:0] cnt_nxt;
    logic [2:0]       flag_set;
    logic             en_clr;

    // ---------------- APB decode ----------------
    assign sel_tdr  = (paddr == ADDR_W'(ADDR_TDR));
    assign sel_tcr  = (paddr == ADDR_W'(ADDR_TCR));
    assign sel_tsr  = (paddr == ADDR_W'(ADDR_TSR));
    assign sel_tcnt = (paddr == ADDR_W'(ADDR_TCNT));
    assign sel_tcmp = (paddr == ADDR_W'(ADDR_TCMP));
    assign sel_tier = (paddr == ADDR_W'(ADDR_TIER));
    assign mapped   = sel_tdr | sel_tcr | sel_tsr | sel_tcnt | sel_tcmp | sel_tier;

    assign access  = psel & penable;
    // Only mapped, writable registers ever see wr; TCNT writes are errored and dropped.
    assign wr      = access & pwrite & mapped & ~sel_tcnt;
    assign pslverr = access & (~mapped | (pwrite & sel_tcnt));
    assign pready  = 1'b1;

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            if (sel_tdr)  prdata = tdr;
            if (sel_tcr)  prdata = WIDTH'(tcr);
            if (sel_tsr)  prdata = WIDTH'(tsr);
            if (sel_tcnt) prdata = tcnt;
            if (sel_tcmp) prdata = tcmp;
            if (sel_tier) prdata = WIDTH'(tier);
        end
    end

    // ---------------- prescaler ----------------
    timer_prescaler u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .run     (tcr[TCR_EN] & ~tcr[TCR_LOAD]),
        .cks     (cks_e'(tcr[2:0])),
        .tick    (tick)
    );

    // ---------------- counter and event detection ----------------
    always_comb begin
        cnt_nxt  = tcnt;
        flag_set = 3'b000;
        en_clr   = 1'b0;
        if (tcr[TCR_LOAD]) begin
            cnt_nxt = tdr;
        end else if (tick) begin
            if (!tcr[TCR_DOWN]) begin
                if (tcnt == '1) begin
                    flag_set[TSR_OVF] = 1'b1;
                    cnt_nxt = tcr[TCR_ARE] ? tdr : '0;
                    en_clr  = tcr[TCR_OSM];
                end else begin
                    cnt_nxt = tcnt + WIDTH'(1);
                end
            end else begin
                if (tcnt == '0) begin
                    flag_set[TSR_UDF] = 1'b1;
                    cnt_nxt = tcr[TCR_ARE] ? tdr : '1;
                    en_clr  = tcr[TCR_OSM];
                end else begin
                    cnt_nxt = tcnt - WIDTH'(1);
                end
            end
            // Compare against the value being loaded, including reload values.
            if (cnt_nxt == tcmp) flag_set[TSR_CMF] = 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tdr     <= '0;
            tcnt    <= '0;
            tcmp    <= '0;
            tcr     <= 8'd0;
            tsr     <= 3'd0;
            tier    <= 3'd0;
            tmr_irq <= 1'b0;
        end else begin
            tcnt <= cnt_nxt;
            if (wr && sel_tdr)  tdr  <= pwdata;
            if (wr && sel_tcmp) tcmp <= pwdata;
            if (wr && sel_tier) tier <= pwdata[2:0];
            // Software write beats the one-shot hardware clear of EN.
            if (wr && sel_tcr) begin
                tcr <= pwdata[7:0];
            end else if (en_clr) begin
                tcr[TCR_EN] <= 1'b0;
            end
            // Write-0-to-clear; a hardware set in the same cycle wins.
            tsr <= ((wr && sel_tsr) ? (tsr & pwdata[2:0]) : tsr) | flag_set;
            // Built from the current flags, so it lags a new flag by one pclk.
            tmr_irq <= |(tsr & tier);
        end
    end

endmodule

// File: tb/tb_timer_param.sv
// Bench for timer_param: an 8-bit and a 16-bit instance share the APB bus
// lines; the stimulus pushes expected responses, the monitor pops and compares.
module tb_timer_param;

    logic        pclk;
    logic        presetn;
    logic        psel8, psel16;
    logic        penable, pwrite;
    logic [7:0]  paddr;
    logic [15:0] pwdata;
    logic [7:0]  prdata8;
    logic [15:0] prdata16;
    logic        pready8, pready16, pslverr8, pslverr16, irq8, irq16;
    logic        probe;

    timer_param #(.WIDTH(8), .ADDR_W(8)) dut8 (
        .pclk(pclk), .presetn(presetn), .psel(psel8), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata[7:0]), .prdata(prdata8),
        .pready(pready8), .pslverr(pslverr8), .tmr_irq(irq8)
    );

    timer_param #(.WIDTH(16), .ADDR_W(8)) dut16 (
        .pclk(pclk), .presetn(presetn), .psel(psel16), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata16),
        .pready(pready16), .pslverr(pslverr16), .tmr_irq(irq16)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct packed {
        logic        inst;     // 0 = 8-bit instance, 1 = 16-bit instance
        logic        chk_dat;
        logic [15:0] dat;
        logic        chk_err;
        logic        err;
        logic        chk_irq;
        logic        irq;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    // ---------------- monitor ----------------
    exp_t        e;
    string       nm;
    logic [15:0] act_dat;
    logic        act_err, act_rdy, act_irq, bad;

    always @(negedge pclk) begin
        if (probe || ((psel8 || psel16) && penable)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: DUT presented an output with no expectation queued");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act_dat = e.inst ? prdata16 : {8'h00, prdata8};
                act_err = e.inst ? pslverr16 : pslverr8;
                act_rdy = e.inst ? pready16 : pready8;
                act_irq = e.inst ? irq16 : irq8;
                bad = (e.chk_dat && (act_dat !== e.dat)) ||
                      (e.chk_err && ((act_err !== e.err) || (act_rdy !== 1'b1))) ||
                      (e.chk_irq && (act_irq !== e.irq));
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got prdata=%h pslverr=%b pready=%b irq=%b, want prdata=%h pslverr=%b irq=%b",
                             nm, act_dat, act_err, act_rdy, act_irq, e.dat, e.err, e.irq);
                end
            end
        end
    end

    // ---------------- stimulus helpers (called #1 after a rising edge) ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic sel(input bit inst);
        psel8  = !inst;
        psel16 = inst;
    endtask

    task automatic idle();
        psel8 = 1'b0; psel16 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Commits on the second rising edge after the call.
    task automatic apb_wr(input bit inst, input logic [7:0] a, input logic [15:0] d,
                          input logic exp_err, input string n);
        exp_q.push_back('{inst: inst, chk_dat: 1'b0, dat: 16'h0, chk_err: 1'b1,
                          err: exp_err, chk_irq: 1'b0, irq: 1'b0});
        name_q.push_back(n);
        sel(inst); penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 idle();
    endtask

    // Observes register state after the first rising edge following the call.
    task automatic apb_rd(input bit inst, input logic [7:0] a, input logic [15:0] d,
                          input logic exp_err, input string n);
        exp_q.push_back('{inst: inst, chk_dat: 1'b1, dat: d, chk_err: 1'b1,
                          err: exp_err, chk_irq: 1'b0, irq: 1'b0});
        name_q.push_back(n);
        sel(inst); penable = 1'b0; pwrite = 1'b0; paddr = a; pwdata = 16'h0;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 idle();
    endtask

    // Observes tmr_irq as left by the rising edge just before the call.
    task automatic probe_irq(input bit inst, input logic exp, input string n);
        exp_q.push_back('{inst: inst, chk_dat: 1'b0, dat: 16'h0, chk_err: 1'b0,
                          err: 1'b0, chk_irq: 1'b1, irq: exp});
        name_q.push_back(n);
        probe = 1'b1;
        @(posedge pclk); #1 probe = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        presetn = 1'b0; probe = 1'b0; paddr = 8'h0; pwdata = 16'h0;
        idle();
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;

        // Reset state
        apb_rd(0, 8'h00, 16'h00, 0, "rst_tdr");
        apb_rd(0, 8'h01, 16'h00, 0, "rst_tcr");
        apb_rd(0, 8'h02, 16'h00, 0, "rst_tsr");
        apb_rd(0, 8'h03, 16'h00, 0, "rst_tcnt");
        apb_rd(0, 8'h04, 16'h00, 0, "rst_tcmp");
        apb_rd(0, 8'h05, 16'h00, 0, "rst_tier");
        probe_irq(0, 1'b0, "rst_irq");
        apb_rd(1, 8'h01, 16'h00, 0, "rst_tcr16");

        // Legacy: down, clk8, TDR=0xFF. Underflow lands 2048 pclk after load release.
        // TCMP is 0, so CMF also fires when the count passes through 0 (tick at +2040).
        apb_wr(0, 8'h00, 16'h00FF, 0, "leg_tdr");
        apb_wr(0, 8'h01, 16'h0082, 0, "leg_tcr_load");
        apb_wr(0, 8'h01, 16'h0032, 0, "leg_tcr_run");
        cyc(499);
        apb_rd(0, 8'h02, 16'h00, 0, "leg_tsr_500");
        apb_rd(0, 8'h03, 16'hC1, 0, "leg_tcnt_502");
        cyc(1541);
        apb_rd(0, 8'h02, 16'h04, 0, "leg_tsr_cmf_2045");
        apb_wr(0, 8'h02, 16'h0003, 0, "leg_clr_cmf");       // commits on the underflow edge
        apb_rd(0, 8'h02, 16'h02, 0, "leg_tsr_udf_2049");
        apb_rd(0, 8'h03, 16'hFF, 0, "leg_tcnt_wrap");
        apb_wr(0, 8'h02, 16'h0007, 0, "leg_tsr_w1");
        apb_rd(0, 8'h02, 16'h02, 0, "leg_tsr_w1_noeffect");
        apb_wr(0, 8'h02, 16'h0000, 0, "leg_tsr_w0");
        apb_rd(0, 8'h02, 16'h00, 0, "leg_tsr_cleared");
        apb_wr(0, 8'h01, 16'h0000, 0, "leg_stop");
        probe_irq(0, 1'b0, "leg_irq_masked");

        // 16-bit up count with auto-reload from 0xFFF0, clk2: overflow on the 16th tick.
        apb_wr(1, 8'h00, 16'hFFF0, 0, "are_tdr");
        apb_wr(1, 8'h01, 16'h00C0, 0, "are_tcr_load");
        apb_wr(1, 8'h01, 16'h0050, 0, "are_tcr_run");
        cyc(30);
        apb_rd(1, 8'h02, 16'h00, 0, "are_tsr_31");
        apb_rd(1, 8'h03, 16'hFFF0, 0, "are_tcnt_reload");
        apb_rd(1, 8'h02, 16'h01, 0, "are_tsr_ovf");
        apb_wr(1, 8'h01, 16'h0000, 0, "are_stop");

        // One-shot down from 3, clk2: underflow at +8 clears EN and holds 0xFF.
        apb_wr(0, 8'h04, 16'h0080, 0, "osm_tcmp");
        apb_wr(0, 8'h00, 16'h0003, 0, "osm_tdr");
        apb_wr(0, 8'h01, 16'h00A8, 0, "osm_tcr_load");
        apb_wr(0, 8'h01, 16'h0038, 0, "osm_tcr_run");
        cyc(6);
        apb_rd(0, 8'h02, 16'h00, 0, "osm_tsr_7");
        apb_rd(0, 8'h02, 16'h02, 0, "osm_tsr_udf");
        apb_rd(0, 8'h01, 16'h28, 0, "osm_en_cleared");
        apb_rd(0, 8'h03, 16'hFF, 0, "osm_tcnt");
        cyc(20);
        apb_rd(0, 8'h03, 16'hFF, 0, "osm_tcnt_held");
        apb_wr(0, 8'h02, 16'h0000, 0, "osm_clr");
        apb_wr(0, 8'h01, 16'h0000, 0, "osm_stop");

        // Compare 0x10 counting up from 0, clk2: CMF at +32, irq at +33, drops 1 pclk after clear.
        apb_wr(0, 8'h04, 16'h0010, 0, "cmp_tcmp");
        apb_wr(0, 8'h05, 16'h0004, 0, "cmp_tier");
        apb_wr(0, 8'h00, 16'h0000, 0, "cmp_tdr");
        apb_wr(0, 8'h01, 16'h0080, 0, "cmp_tcr_load");
        apb_wr(0, 8'h01, 16'h0010, 0, "cmp_tcr_run");
        cyc(30);
        apb_rd(0, 8'h02, 16'h00, 0, "cmp_tsr_31");
        probe_irq(0, 1'b0, "cmp_irq_32");
        probe_irq(0, 1'b1, "cmp_irq_33");
        apb_rd(0, 8'h02, 16'h04, 0, "cmp_tsr_cmf");
        apb_wr(0, 8'h02, 16'h0003, 0, "cmp_clr");
        probe_irq(0, 1'b1, "cmp_irq_at_clear");
        probe_irq(0, 1'b0, "cmp_irq_dropped");
        apb_wr(0, 8'h01, 16'h0000, 0, "cmp_stop");

        // Bus errors
        apb_wr(0, 8'h00, 16'h005A, 0, "err_tdr");
        apb_wr(0, 8'h01, 16'h0080, 0, "err_tcr_load");
        apb_wr(0, 8'h01, 16'h0000, 0, "err_tcr_stop");
        apb_wr(0, 8'h03, 16'h0011, 1, "err_wr_tcnt");
        apb_rd(0, 8'h03, 16'h5A, 0, "err_tcnt_unchanged");
        apb_rd(0, 8'h07, 16'h00, 1, "err_rd_unmapped");
        apb_wr(0, 8'h07, 16'h00FF, 1, "err_wr_unmapped");
        apb_rd(0, 8'h05, 16'h04, 0, "err_tier_intact");
        apb_rd(0, 8'h04, 16'h10, 0, "err_tcmp_intact");

        // Reset mid-count; a glitch between edges must not reset anything.
        apb_wr(0, 8'h04, 16'h005B, 0, "rst_tcmp_5b");
        apb_wr(0, 8'h01, 16'h0010, 0, "rst_tcr_run");
        #2 presetn = 1'b0;
        #2 presetn = 1'b1;
        @(posedge pclk); #1;
        cyc(2);
        probe_irq(0, 1'b1, "glitch_irq_kept");
        apb_rd(0, 8'h02, 16'h04, 0, "glitch_tsr_kept");
        apb_rd(0, 8'h03, 16'h5D, 0, "glitch_tcnt_counting");
        presetn = 1'b0;
        @(posedge pclk); #1 presetn = 1'b1;
        probe_irq(0, 1'b0, "mid_rst_irq");
        apb_rd(0, 8'h00, 16'h00, 0, "mid_rst_tdr");
        apb_rd(0, 8'h01, 16'h00, 0, "mid_rst_tcr");
        apb_rd(0, 8'h02, 16'h00, 0, "mid_rst_tsr");
        apb_rd(0, 8'h03, 16'h00, 0, "mid_rst_tcnt");
        apb_rd(0, 8'h04, 16'h00, 0, "mid_rst_tcmp");
        apb_rd(0, 8'h05, 16'h00, 0, "mid_rst_tier");
        apb_rd(1, 8'h00, 16'h00, 0, "mid_rst_tdr16");

        cyc(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never observed, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
